alu_scalar_arbiter: RTL and testbench
=====================================

# alu_scalar_arbiter

Round-robin arbiter and sequencer that shares one combinational 18-bit scalar ALU among R requesters (vector-lane control units) in the filter GPU. It accepts one operation at a time and drives registered operands and a function code into the ALU. It holds multiplies for a configurable number of cycles, then captures the result and the {Negative, Zero, Carry, Overflow} flags into registers. It returns them to the winning requester with a one-cycle done pulse and rejects function codes the ALU does not define.

## Interface
- N, 18, operand/result width; must equal the ALU width
- R, 4, number of requesters (2..8)
- MUL_LAT, 2, cycles the ALU inputs are held for F=100 (1..8); all other ops take 1 cycle
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  R  per-requester request level; held until gnt
- req_a  in  R*N  operand A, requester i at [i*N +: N]
- req_b  in  R*N  operand B, same packing
- req_f  in  R*3  function code, requester i at [i*3 +: 3]
- gnt  out  R  one-hot, one-cycle pulse; operands were latched
- done  out  R  one-hot, one-cycle pulse; result, flags and err are valid
- result  out  N  registered ALU result, shared by all requesters
- flags  out  4  registered {Negative, Zero, Carry, Overflow}
- err  out  1  high with done when the granted F was 101..111
- busy  out  1  high in EXEC and RESP
- alu_a, alu_b  out  N  registered ALU operands
- alu_f  out  3  registered ALU function code
- alu_result  in  N  ALU Result
- alu_flags  in  4  ALU {Negative, Zero, Carry, Overflow}

## Operation
- Reset: state IDLE; ptr=0; all outputs 0; cnt=0; owner=0.
- States: IDLE, EXEC, RESP.
- Arbitration happens in IDLE only. The winner is the first set bit of req searched from ptr upward, wrapping modulo R.
- IDLE with req != 0, valid F (000..100):
  - alu_a/alu_b/alu_f are loaded from the winner's lane.
  - owner is set to the winner; gnt is set to the winner's one-hot.
  - cnt is MUL_LAT-1 if F=100, else 0.
  - Next state EXEC.
- IDLE with winner F in 101..111:
  - The ALU registers are not loaded and keep their previous values.
  - gnt and done both pulse for the winner; err=1, result=0, flags=0.
  - Next state RESP.
- IDLE with req == 0: stay in IDLE; all outputs hold.
- EXEC with cnt != 0: decrement cnt; alu_* hold.
- EXEC with cnt == 0:
  - result is set to alu_result and flags to alu_flags; err=0.
  - done pulses for owner.
  - Next state RESP.
- RESP: ptr is set to (owner+1) mod R; next state IDLE. result, flags and err hold until the next capture.
- gnt is cleared on the cycle after it is set. done is high only during the RESP cycle.
- req is ignored outside IDLE. A requester that keeps req high after gnt is re-arbitrated as a new operation.
- The controller passes flags through from the ALU and does not reinterpret them.

## Timing
- Cycle numbering: edge 0 samples req in IDLE; cycle 1 follows edge 0.
- Non-multiply op: gnt and alu_* valid in cycle 1, done in cycle 2, next earliest gnt in cycle 4. Throughput is one op per 3 cycles.
- Multiply: gnt in cycle 1; alu_* held for cycles 1..MUL_LAT; done in cycle MUL_LAT+1.
- Invalid F: gnt, done and err=1 all in cycle 1; next earliest gnt in cycle 3.
- Requests raised during EXEC or RESP are sampled at the first IDLE edge.
- Reset asserted mid-operation clears state immediately. No done is emitted for the aborted op, and ptr returns to 0.
- Single requester held continuously is granted every 3 cycles with no starvation.

## Test plan
- ADD with carry: req[1]=1, A=18'h3FFFF, B=1, F=010 -> gnt=0010 in cycle 1; alu_a=3FFFF; done=0010 in cycle 2; result=0; flags Zero=1, Carry=1.
- Multiply: MUL_LAT=2, req[0], A=3, B=5, F=100 -> gnt cycle 1; alu_f=100 held in cycles 1-2; done cycle 3; result=15.
- Round-robin fairness: req=1111 held, all F=001 -> grant order 0,1,2,3,0,1 at cycles 1,4,7,10,13,16; no done overlaps.
- Invalid code: req[2], F=110 -> gnt=done=0100 in cycle 1; err=1, result=0, flags=0; alu_f unchanged; next grant possible in cycle 3.
- Reset mid-multiply: MUL_LAT=4, rst_n low in cycle 2 -> all outputs 0 immediately, no done. After release, req=1000 -> gnt=1000 (ptr restarted at 0).
- Priority wrap: after a grant to requester 3, req=1001 -> requester 0 granted next.

Source files
------------

// File: rtl/alu_scalar_arbiter.sv
// Round-robin sequencer sharing one combinational scalar ALU among R requesters.
// Registers operands into the ALU, waits out multiply latency, and returns result/flags with a done pulse.
module alu_scalar_arbiter #(
    parameter int N       = 18,
    parameter int R       = 4,
    parameter int MUL_LAT = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [R-1:0]   req,
    input  logic [R*N-1:0] req_a,
    input  logic [R*N-1:0] req_b,
    input  logic [R*3-1:0] req_f,
    output logic [R-1:0]   gnt,
    output logic [R-1:0]   done,
    output logic [N-1:0]   result,
    output logic [3:0]     flags,
    output logic           err,
    output logic           busy,
    output logic [N-1:0]   alu_a,
    output logic [N-1:0]   alu_b,
    output logic [2:0]     alu_f,
    input  logic [N-1:0]   alu_result,
    input  logic [3:0]     alu_flags
);

    localparam int PW = (R > 1) ? $clog2(R) : 1;
    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT + 1) : 1;
    localparam logic [2:0] F_MUL = 3'b100;
    localparam logic [R-1:0] ONE = {{(R-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   owner;
    logic [CW-1:0]   cnt;

    logic            win_vld;
    logic [PW-1:0]   win;
    logic [2:0]      win_f;
    logic [N-1:0]    win_a;
    logic [N-1:0]    win_b;
    int unsigned     idx;

    // Scan from ptr upward; iterating high-to-low lets the nearest set bit win.
    always_comb begin
        win_vld = 1'b0;
        win     = '0;
        idx     = 0;
        for (int i = R - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % R;
            if (req[idx]) begin
                win_vld = 1'b1;
                win     = PW'(idx);
            end
        end
    end

    assign win_f = req_f[int'(win)*3 +: 3];
    assign win_a = req_a[int'(win)*N +: N];
    assign win_b = req_b[int'(win)*N +: N];
    assign busy  = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ptr    <= '0;
            owner  <= '0;
            cnt    <= '0;
            gnt    <= '0;
            done   <= '0;
            result <= '0;
            flags  <= '0;
            err    <= 1'b0;
            alu_a  <= '0;
            alu_b  <= '0;
            alu_f  <= '0;
        end else begin
            gnt  <= '0;
            done <= '0;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        owner <= win;
                        gnt   <= ONE << win;
                        if (win_f <= F_MUL) begin
                            alu_a <= win_a;
                            alu_b <= win_b;
                            alu_f <= win_f;
                            cnt   <= (win_f == F_MUL) ? CW'(MUL_LAT - 1) : '0;
                            state <= EXEC;
                        end else begin
                            // Undefined function code: answer immediately, ALU inputs untouched.
                            done   <= ONE << win;
                            err    <= 1'b1;
                            result <= '0;
                            flags  <= '0;
                            state  <= RESP;
                        end
                    end
                end
                EXEC: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        result <= alu_result;
                        flags  <= alu_flags;
                        err    <= 1'b0;
                        done   <= ONE << owner;
                        state  <= RESP;
                    end
                end
                RESP: begin
                    ptr   <= (int'(owner) == R - 1) ? '0 : owner + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_scalar_arbiter.sv
// Directed bench for alu_scalar_arbiter with a behavioural ALU and a done-result scoreboard.
module tb_alu_scalar_arbiter;

    localparam int N       = 18;
    localparam int R       = 4;
    localparam int MUL_LAT = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [R-1:0]   req;
    logic [R*N-1:0] req_a;
    logic [R*N-1:0] req_b;
    logic [R*3-1:0] req_f;
    logic [R-1:0]   gnt;
    logic [R-1:0]   done;
    logic [N-1:0]   result;
    logic [3:0]     flags;
    logic           err;
    logic           busy;
    logic [N-1:0]   alu_a;
    logic [N-1:0]   alu_b;
    logic [2:0]     alu_f;
    logic [N-1:0]   alu_result;
    logic [3:0]     alu_flags;

    always #5 clk = ~clk;

    alu_scalar_arbiter #(.N(N), .R(R), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b), .req_f(req_f),
        .gnt(gnt), .done(done), .result(result), .flags(flags), .err(err), .busy(busy),
        .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
        .alu_result(alu_result), .alu_flags(alu_flags)
    );

    typedef struct packed {
        logic [R-1:0] who;
        logic [N-1:0] res;
        logic [3:0]   flg;
        logic         e;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Reference ALU: returns {N,Z,C,V, result}
    function automatic logic [N+3:0] alu_model(input logic [N-1:0] a, input logic [N-1:0] b,
                                               input logic [2:0] f);
        logic [N:0]     s;
        logic [2*N-1:0] p;
        logic [N-1:0]   r;
        logic           c;
        logic           v;
        s = '0; p = '0; r = '0; c = 1'b0; v = 1'b0;
        case (f)
            3'b000: r = a & b;
            3'b001: r = a | b;
            3'b010: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[N-1:0]; c = s[N];
                v = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
            end
            3'b011: begin
                s = {1'b0, a} - {1'b0, b};
                r = s[N-1:0]; c = s[N];
                v = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]);
            end
            3'b100: begin
                p = a * b;
                r = p[N-1:0]; c = |p[2*N-1:N];
            end
            default: r = '0;
        endcase
        return {r[N-1], (r == '0), c, v, r};
    endfunction

    assign {alu_flags, alu_result} = alu_model(alu_a, alu_b, alu_f);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [N-1:0] a, input logic [N-1:0] b,
                            input logic [2:0] f);
        req_a[i*N +: N] = a;
        req_b[i*N +: N] = b;
        req_f[i*3 +: 3] = f;
    endtask

    task automatic expect_op(input int i, input logic [N-1:0] a, input logic [N-1:0] b,
                             input logic [2:0] f);
        exp_t        e;
        logic [N+3:0] m;
        m     = alu_model(a, b, f);
        e.who = R'(1) << i;
        if (f > 3'b100) begin
            e.res = '0; e.flg = '0; e.e = 1'b1;
        end else begin
            e.res = m[N-1:0]; e.flg = m[N+3:N]; e.e = 1'b0;
        end
        sb.push_back(e);
    endtask

    // Scoreboard: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done != '0) begin
            if (sb.size() == 0) begin
                check("done_unexpected", 64'(done), 64'(0));
            end else begin
                mon_e = sb.pop_front();
                check("done_who", 64'(done), 64'(mon_e.who));
                check("done_result", 64'(result), 64'(mon_e.res));
                check("done_flags", 64'(flags), 64'(mon_e.flg));
                check("done_err", 64'(err), 64'(mon_e.e));
            end
        end
    end

    initial begin
        exp_t e;
        rst_n = 1'b0;
        req   = '0;
        req_a = '0;
        req_b = '0;
        req_f = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt", 64'(gnt), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_result", 64'(result), 64'(0));
        check("rst_flags", 64'(flags), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_alu_a", 64'(alu_a), 64'(0));
        check("rst_alu_f", 64'(alu_f), 64'(0));
        rst_n = 1'b1;
        tick();

        // Round-robin with all four requesting OR operations
        for (int i = 0; i < R; i++) set_lane(i, N'(i * 7 + 1), N'(18'h10 << i), 3'b001);
        for (int k = 0; k < 6; k++) expect_op(k % R, N'((k % R) * 7 + 1), N'(18'h10 << (k % R)), 3'b001);
        req = '1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("rr_gnt%0d", k), 64'(gnt), 64'(R'(1) << (k % R)));
            check($sformatf("rr_busy%0d", k), 64'(busy), 64'(1));
            if (k == 5) req = '0;
            tick();
            check($sformatf("rr_gap%0d", k), 64'(gnt), 64'(0));
            tick();
        end

        // ADD with carry out and zero result
        set_lane(1, 18'h3FFFF, 18'h00001, 3'b010);
        req = 4'b0010;
        e.who = 4'b0010; e.res = '0; e.flg = 4'b0110; e.e = 1'b0;
        sb.push_back(e);
        tick();
        check("add_gnt", 64'(gnt), 64'(4'b0010));
        check("add_alu_a", 64'(alu_a), 64'(18'h3FFFF));
        check("add_alu_b", 64'(alu_b), 64'(1));
        check("add_alu_f", 64'(alu_f), 64'(3'b010));
        req = '0;
        tick();
        check("add_done", 64'(done), 64'(4'b0010));
        check("add_gnt_clr", 64'(gnt), 64'(0));
        tick();
        check("add_idle", 64'(busy), 64'(0));
        check("add_done_clr", 64'(done), 64'(0));

        // Multiply holds ALU inputs for MUL_LAT cycles
        set_lane(0, 18'd3, 18'd5, 3'b100);
        req = 4'b0001;
        expect_op(0, 18'd3, 18'd5, 3'b100);
        tick();
        check("mul_gnt", 64'(gnt), 64'(4'b0001));
        check("mul_alu_f1", 64'(alu_f), 64'(3'b100));
        req = '0;
        tick();
        check("mul_alu_f2", 64'(alu_f), 64'(3'b100));
        check("mul_no_done", 64'(done), 64'(0));
        check("mul_busy", 64'(busy), 64'(1));
        tick();
        check("mul_done", 64'(done), 64'(4'b0001));
        check("mul_result", 64'(result), 64'(15));
        tick();
        check("mul_idle", 64'(busy), 64'(0));

        // Undefined function code is rejected in one cycle
        set_lane(2, 18'd7, 18'd9, 3'b110);
        req = 4'b0100;
        expect_op(2, 18'd7, 18'd9, 3'b110);
        tick();
        check("inv_gnt", 64'(gnt), 64'(4'b0100));
        check("inv_done", 64'(done), 64'(4'b0100));
        check("inv_err", 64'(err), 64'(1));
        check("inv_alu_f", 64'(alu_f), 64'(3'b100));
        set_lane(2, 18'h0F0F0, 18'h0FF00, 3'b000);
        expect_op(2, 18'h0F0F0, 18'h0FF00, 3'b000);
        tick();
        check("inv_gap", 64'(gnt), 64'(0));
        tick();
        check("inv_next_gnt", 64'(gnt), 64'(4'b0100));
        check("inv_next_alu_f", 64'(alu_f), 64'(3'b000));
        req = '0;
        tick();
        tick();

        // Pointer wrap: requester 3 then requester 0
        set_lane(3, 18'h20000, 18'd3, 3'b011);
        set_lane(0, 18'd5, 18'd1, 3'b010);
        req = 4'b1001;
        expect_op(3, 18'h20000, 18'd3, 3'b011);
        expect_op(0, 18'd5, 18'd1, 3'b010);
        tick();
        check("wrap_gnt3", 64'(gnt), 64'(4'b1000));
        tick();
        tick();
        tick();
        check("wrap_gnt0", 64'(gnt), 64'(4'b0001));
        req = '0;
        tick();
        tick();

        // Reset during a multiply aborts it without done
        set_lane(1, 18'd100, 18'd200, 3'b100);
        req = 4'b0010;
        tick();
        check("abort_gnt", 64'(gnt), 64'(4'b0010));
        req = '0;
        tick();
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_result", 64'(result), 64'(0));
        check("abort_flags", 64'(flags), 64'(0));
        check("abort_alu_a", 64'(alu_a), 64'(0));
        check("abort_alu_f", 64'(alu_f), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        set_lane(3, 18'd1, 18'd2, 3'b001);
        req = 4'b1000;
        expect_op(3, 18'd1, 18'd2, 3'b001);
        tick();
        check("post_rst_gnt", 64'(gnt), 64'(4'b1000));
        req = '0;
        repeat (4) tick();

        check("sb_drained", 64'(sb.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
